// File: rtl/filt_tx.sv
// Transmit line shaper: every driven level is held for at least MIN_HOLD cycles.
// Optional suppressed-change counter enabled by defining FILT_TX_GLITCH_CNT_EN.
module filt_tx #(
    parameter int unsigned MIN_HOLD = 3,
    parameter int unsigned CW       = 4,
    parameter int unsigned GW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          d,
    output logic          o,
    output logic          busy,
    output logic          pend
`ifdef FILT_TX_GLITCH_CNT_EN
    ,
    output logic [GW-1:0] glitch_cnt
`endif
);

    typedef enum logic [1:0] {
        StIdleLo = 2'd0,
        StHoldLo = 2'd1,
        StIdleHi = 2'd2,
        StHoldHi = 2'd3
    } state_e;

    localparam logic [CW-1:0] HoldLoad = CW'(MIN_HOLD - 1);

    state_e        state_q, state_d;
    logic          o_q, o_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        o_d     = o_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdleLo: begin
                if (d) begin
                    state_d = StHoldHi;
                    o_d     = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = HoldLoad;
                end
            end
            StIdleHi: begin
                if (!d) begin
                    state_d = StHoldLo;
                    o_d     = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = HoldLoad;
                end
            end
            StHoldHi: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!d) begin
                    // Back-to-back hold: the final-cycle request wins.
                    state_d = StHoldLo;
                    o_d     = 1'b0;
                    cnt_d   = HoldLoad;
                end else begin
                    state_d = StIdleHi;
                    busy_d  = 1'b0;
                end
            end
            StHoldLo: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (d) begin
                    state_d = StHoldHi;
                    o_d     = 1'b1;
                    cnt_d   = HoldLoad;
                end else begin
                    state_d = StIdleLo;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdleLo;
                o_d     = 1'b0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdleLo;
            o_q     <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            o_q     <= o_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o    = o_q;
    assign busy = busy_q;
    assign pend = busy_q & (d ^ o_q);

`ifdef FILT_TX_GLITCH_CNT_EN
    logic          seen_q, seen_d;
    logic [GW-1:0] glitch_q, glitch_d;
    logic          in_hold;

    assign in_hold = (state_q == StHoldHi) || (state_q == StHoldLo);

    // A hold that saw a differing request but ends with d == o absorbed a glitch.
    always_comb begin
        seen_d   = 1'b0;
        glitch_d = glitch_q;
        if (in_hold) begin
            if (cnt_q != '0) begin
                seen_d = seen_q | (d ^ o_q);
            end else if ((d == o_q) && seen_q && (glitch_q != '1)) begin
                glitch_d = glitch_q + GW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seen_q   <= 1'b0;
            glitch_q <= '0;
        end else begin
            seen_q   <= seen_d;
            glitch_q <= glitch_d;
        end
    end

    assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_filt_tx.sv
// Self-checking bench for filt_tx: directed vector table, glitch-count sequence and
// randomized run against a time-since-last-change reference model.
module tb_filt_tx;

    localparam int MH   = 3;
    localparam int GMAX = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic d   = 1'b0;
    logic o, busy, pend;
`ifdef FILT_TX_GLITCH_CNT_EN
    logic [1:0] glitch_cnt;
`endif

    filt_tx #(
        .MIN_HOLD(MH),
        .CW      (4),
        .GW      (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .d         (d),
        .o         (o),
        .busy      (busy),
        .pend      (pend)
`ifdef FILT_TX_GLITCH_CNT_EN
        ,
        .glitch_cnt(glitch_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: o may follow d only once MH edges have passed since its last change.
    int   m_since = MH + 1;
    logic m_o     = 1'b0;
    logic m_seen  = 1'b0;
    int   m_g     = 0;

    task automatic model_step(input logic r, input logic dv);
        bit allowed;
        bit hold;
        if (r) begin
            m_o     = 1'b0;
            m_since = MH + 1;
            m_seen  = 1'b0;
            m_g     = 0;
        end else begin
            allowed = (m_since >= MH);
            hold    = (m_since <= MH);
            if (hold && !allowed && (dv != m_o)) m_seen = 1'b1;
            if (hold && allowed) begin
                if ((dv == m_o) && m_seen && (m_g < GMAX)) m_g++;
                m_seen = 1'b0;
            end
            if (allowed && (dv != m_o)) begin
                m_o     = dv;
                m_since = 1;
            end else if (m_since <= MH) begin
                m_since++;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input logic r, input logic dv);
        rst = r;
        d   = dv;
        @(posedge clk);
        model_step(r, dv);
        #1;
    endtask

    typedef struct packed {
        logic r;
        logic d;
        logic o;
        logic busy;
        logic pend;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic dv, input logic eo, input logic eb,
                       input logic ep);
        vec_t v;
        v.r = r; v.d = dv; v.o = eo; v.busy = eb; v.pend = ep;
        vecs.push_back(v);
    endtask

    initial begin
        // reset, then idle low
        add(1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0); add(0, 0, 0, 0, 0); add(0, 0, 0, 0, 0);
        // rise and stay: busy for three cycles
        add(0, 1, 1, 1, 0); add(0, 1, 1, 1, 0); add(0, 1, 1, 1, 0);
        add(0, 1, 1, 0, 0); add(0, 1, 1, 0, 0);
        // one-cycle low request: held low 3 cycles, then back-to-back high hold
        add(0, 0, 0, 1, 0); add(0, 1, 0, 1, 1); add(0, 1, 0, 1, 1);
        add(0, 1, 1, 1, 0); add(0, 1, 1, 1, 0); add(0, 1, 1, 1, 0);
        add(0, 1, 1, 0, 0);
        // reset mid HOLD_HI with d=0, then restart
        add(1, 0, 0, 0, 0);
        add(0, 1, 1, 1, 0); add(0, 0, 1, 1, 1);
        add(1, 0, 0, 0, 0);
        add(0, 1, 1, 1, 0); add(0, 1, 1, 1, 0); add(0, 1, 1, 1, 0);
        add(0, 1, 1, 0, 0);
        // toggle every cycle: runs of exactly three
        add(0, 0, 0, 1, 0); add(0, 1, 0, 1, 1); add(0, 0, 0, 1, 0);
        add(0, 1, 1, 1, 0); add(0, 0, 1, 1, 1); add(0, 1, 1, 1, 0);
        add(0, 0, 0, 1, 0); add(0, 1, 0, 1, 1); add(0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].r, vecs[i].d);
            chk($sformatf("vec%0d_o", i), int'(o), int'(vecs[i].o));
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].busy));
            chk($sformatf("vec%0d_pend", i), int'(pend), int'(vecs[i].pend));
        end

        // five holds each with a one-cycle revert; counter saturates at 3
        tick(1, 0);
`ifdef FILT_TX_GLITCH_CNT_EN
        chk("glitch_reset", int'(glitch_cnt), 0);
`endif
        for (int k = 0; k < 5; k++) begin
            logic lvl;
            lvl = (k % 2 == 0) ? 1'b1 : 1'b0;
            tick(0, lvl);
            chk($sformatf("ghold%0d_entry_o", k), int'(o), int'(lvl));
            tick(0, ~lvl);
            chk($sformatf("ghold%0d_pend", k), int'(pend), 1);
            tick(0, lvl);
            tick(0, lvl);
            chk($sformatf("ghold%0d_end_busy", k), int'(busy), 0);
            chk($sformatf("ghold%0d_end_o", k), int'(o), int'(lvl));
`ifdef FILT_TX_GLITCH_CNT_EN
            chk($sformatf("ghold%0d_cnt", k), int'(glitch_cnt), (k + 1 < GMAX) ? k + 1 : GMAX);
`endif
        end

        // randomized run against the reference model
        tick(1, 0);
        for (int i = 0; i < 600; i++) begin
            logic r;
            logic dv;
            r  = ($urandom_range(0, 59) == 0);
            dv = (i % 100 < 50) ? 1'($urandom_range(0, 1))
                                : (($urandom_range(0, 3) == 0) ? ~d : d);
            tick(r, dv);
            chk("rand_o", int'(o), int'(m_o));
            chk("rand_busy", int'(busy), int'(m_since <= MH));
            chk("rand_pend", int'(pend), int'((m_since <= MH) && (dv != m_o)));
`ifdef FILT_TX_GLITCH_CNT_EN
            chk("rand_glitch", int'(glitch_cnt), m_g);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
